// File: rtl/address_dec_burst.sv
// Register-bank address decoder: command byte selects R/W and start address, data bytes/read requests walk the bank.
// Latency: every accepted byte or read request is answered exactly one cycle later (ack/strobe/data all registered).
// Backpressure: none; accepts a byte or read request every cycle, ignored strobes (wrong direction) get no answer.
//
// Ports:
//   clk, rst (async active-low)      clock and reset
//   rx_valid/rx_data/rx_stop/tx_req  byte, end-of-transaction and read-request strobes from the protocol FSM
//   data_received/nack               per-byte ack and out-of-range flag
//   tx_valid/tx_data                 read byte back to the protocol FSM
//   address/w_data/wr/rd/cs/q        register file interface
// Optional build macro ADDR_DEC_WRAP_EN: burst address wraps from NUM_REGS-1 to 0 instead of running modulo 2**ADDR_W.
module address_dec_burst #(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 122,
    parameter int AUTO_INC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_stop,
    input  logic                     tx_req,
    output logic                     data_received,
    output logic                     nack,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic [ADDR_W-1:0]        address,
    output logic [7:0]               w_data,
    output logic                     wr,
    output logic                     rd,
    output logic [NUM_REGS-1:0]      cs,
    input  logic [NUM_REGS-1:0][7:0] q
);

    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [7:0]        w_data_q, w_data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              tx_valid_q, tx_valid_d;
    logic              data_received_q, data_received_d;
    logic              nack_q, nack_d;

    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] cmd_addr;
    logic              inc_pending;
    logic [7:0]        rd_byte;
    logic              cs_en;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_W);
    endfunction

    always_comb begin
        addr_inc = address_q + ADDR_W'(1);
`ifdef ADDR_DEC_WRAP_EN
        if (address_q == LAST_ADDR) begin
            addr_inc = '0;
        end
`endif
    end

    // The increment belonging to last cycle's strobe lands at the end of the
    // strobe cycle, so a back-to-back access must already target the bumped
    // address; addr_next is the address the next access will use.
    assign inc_pending = (AUTO_INC != 0) && (wr_q || rd_q);
    assign addr_next   = inc_pending ? addr_inc : address_q;
    assign cmd_addr    = rx_data[ADDR_W-1:0];

    // Read mux; addresses past the bank fall through to zero.
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_next == ADDR_W'(i)) begin
                rd_byte = q[i];
            end
        end
    end

    // Selection stays live during a strobe even if a stop already returned the
    // state to IDLE, so the last byte of a stopped burst still lands.
    assign cs_en = (state_q != ST_IDLE) || wr_q || rd_q;

    always_comb begin
        cs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cs[i] = cs_en && (address_q == ADDR_W'(i));
        end
    end

    always_comb begin
        state_d         = state_q;
        address_d       = addr_next;
        w_data_d        = w_data_q;
        tx_data_d       = tx_data_q;
        wr_d            = 1'b0;
        rd_d            = 1'b0;
        tx_valid_d      = 1'b0;
        data_received_d = 1'b0;
        nack_d          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    state_d         = rx_data[7] ? ST_WRITE : ST_READ;
                    address_d       = cmd_addr;
                    data_received_d = 1'b1;
                    nack_d          = !in_range(cmd_addr);
                end
            end
            ST_WRITE: begin
                if (rx_valid) begin
                    wr_d            = 1'b1;
                    w_data_d        = rx_data;
                    data_received_d = 1'b1;
                    nack_d          = !in_range(addr_next);
                end
            end
            ST_READ: begin
                if (tx_req) begin
                    rd_d       = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rd_byte;
                    nack_d     = !in_range(addr_next);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_stop) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            address_q       <= '0;
            w_data_q        <= '0;
            tx_data_q       <= '0;
            wr_q            <= 1'b0;
            rd_q            <= 1'b0;
            tx_valid_q      <= 1'b0;
            data_received_q <= 1'b0;
            nack_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            address_q       <= address_d;
            w_data_q        <= w_data_d;
            tx_data_q       <= tx_data_d;
            wr_q            <= wr_d;
            rd_q            <= rd_d;
            tx_valid_q      <= tx_valid_d;
            data_received_q <= data_received_d;
            nack_q          <= nack_d;
        end
    end

    assign address       = address_q;
    assign w_data        = w_data_q;
    assign tx_data       = tx_data_q;
    assign wr            = wr_q;
    assign rd            = rd_q;
    assign tx_valid      = tx_valid_q;
    assign data_received = data_received_q;
    assign nack          = nack_q;

endmodule

// File: tb/tb_address_dec_burst.sv
// Bench for address_dec_burst: directed bursts plus random traffic against a transaction-level model.
// Latency: model expects each answer one cycle after the stimulus cycle.
// Backpressure: n/a; stimulus is driven every cycle.
module tb_address_dec_burst;

    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 122;
    localparam int AUTO_INC = 1;

    localparam int M_IDLE = 0;
    localparam int M_WR   = 1;
    localparam int M_RD   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     rx_stop;
    logic                     tx_req;
    logic                     data_received;
    logic                     nack;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic [ADDR_W-1:0]        address;
    logic [7:0]               w_data;
    logic                     wr;
    logic                     rd;
    logic [NUM_REGS-1:0]      cs;
    logic [NUM_REGS-1:0][7:0] q;

    // Register file seen by the DUT, and the model's own copy of it.
    logic [7:0] regs  [NUM_REGS];
    logic [7:0] mregs [NUM_REGS];

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state: mode and the address of the next access.
    int         m_mode;
    int         m_addr;
    logic       e_dr, e_nack, e_wr, e_rd, e_txv;
    logic [7:0] e_wd, e_txd;
    int         e_addr;
    logic [127:0] e_cs;

    address_dec_burst #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .AUTO_INC (AUTO_INC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_stop       (rx_stop),
        .tx_req        (tx_req),
        .data_received (data_received),
        .nack          (nack),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .address       (address),
        .w_data        (w_data),
        .wr            (wr),
        .rd            (rd),
        .cs            (cs),
        .q             (q)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            q[i] = regs[i];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic inr(input int a);
        return a < NUM_REGS;
    endfunction

    function automatic int next_addr(input int a);
        if (AUTO_INC == 0) return a;
`ifdef ADDR_DEC_WRAP_EN
        if (a == NUM_REGS - 1) return 0;
`endif
        return (a + 1) % (1 << ADDR_W);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_addr = 0;
        e_wd   = 8'h00;
        e_txd  = 8'h00;
    endtask

    // Compute what the DUT must show in the cycle after these inputs.
    task automatic model_step(input logic v, input logic [7:0] d, input logic s, input logic t);
        e_dr = 0; e_nack = 0; e_wr = 0; e_rd = 0; e_txv = 0;
        e_addr = m_addr;
        if (m_mode == M_IDLE) begin
            if (v) begin
                m_mode = d[7] ? M_WR : M_RD;
                m_addr = int'(d[6:0]);
                e_addr = m_addr;
                e_dr   = 1;
                e_nack = !inr(m_addr);
            end
        end else if (m_mode == M_WR) begin
            if (v) begin
                e_wr   = 1;
                e_wd   = d;
                e_dr   = 1;
                e_nack = !inr(m_addr);
                if (inr(m_addr)) mregs[m_addr] = d;
                m_addr = next_addr(m_addr);
            end
        end else begin
            if (t) begin
                e_rd   = 1;
                e_txv  = 1;
                e_txd  = inr(m_addr) ? mregs[m_addr] : 8'h00;
                e_nack = !inr(m_addr);
                m_addr = next_addr(m_addr);
            end
        end
        if (s) m_mode = M_IDLE;
        if (((m_mode != M_IDLE) || e_wr || e_rd) && inr(e_addr))
            e_cs = 128'd1 << e_addr;
        else
            e_cs = '0;
    endtask

    task automatic check_outputs();
        chk("data_received", 128'(data_received), 128'(e_dr));
        chk("nack",          128'(nack),          128'(e_nack));
        chk("wr",            128'(wr),            128'(e_wr));
        chk("rd",            128'(rd),            128'(e_rd));
        chk("tx_valid",      128'(tx_valid),      128'(e_txv));
        chk("address",       128'(address),       128'(e_addr));
        chk("cs",            128'(cs),            e_cs);
        if (e_wr)  chk("w_data",  128'(w_data),  128'(e_wd));
        if (e_txv) chk("tx_data", 128'(tx_data), 128'(e_txd));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dr"},   128'(data_received), 128'd0);
        chk({tag, "_nack"}, 128'(nack),          128'd0);
        chk({tag, "_wr"},   128'(wr),            128'd0);
        chk({tag, "_rd"},   128'(rd),            128'd0);
        chk({tag, "_txv"},  128'(tx_valid),      128'd0);
        chk({tag, "_txd"},  128'(tx_data),       128'd0);
        chk({tag, "_wd"},   128'(w_data),        128'd0);
        chk({tag, "_addr"}, 128'(address),       128'd0);
        chk({tag, "_cs"},   128'(cs),            128'd0);
    endtask

    // One stimulus cycle; entered and left on a falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic t);
        rx_valid = v; rx_data = d; rx_stop = s; tx_req = t;
        model_step(v, d, s, t);
        @(posedge clk);
        #1;
        rx_valid = 0; rx_stop = 0; tx_req = 0;
        check_outputs();
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr && cs[i]) regs[i] = w_data;
        end
        @(negedge clk);
    endtask

    initial begin
        int nbad_regs;
        logic v, s, t;
        logic [7:0] d;

        rst = 0; rx_valid = 0; rx_data = 0; rx_stop = 0; tx_req = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i]  = 8'($urandom);
            mregs[i] = regs[i];
        end
        regs[10] = 8'h3C; mregs[10] = 8'h3C;
        regs[11] = 8'h5A; mregs[11] = 8'h5A;
        model_reset();
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1;

        // Write burst at 5, 6.
        cyc(1, 8'h85, 0, 0);
        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("wburst_r5", 128'(regs[5]), 128'hAA);
        chk("wburst_r6", 128'(regs[6]), 128'hBB);

        // Read burst from 10, one idle cycle then back-to-back requests.
        cyc(1, 8'h0A, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1);
        chk("rburst_0", 128'(tx_data), 128'h3C);
        cyc(0, 8'h00, 0, 1);
        chk("rburst_1", 128'(tx_data), 128'h5A);
        cyc(1, 8'h55, 1, 0);

        // Out-of-range write.
        cyc(1, 8'hFD, 0, 0);
        cyc(1, 8'h11, 0, 0);
        cyc(0, 8'h00, 1, 0);

        // Boundary burst across the top of the bank.
        cyc(1, 8'hF9, 0, 0);
        cyc(1, 8'h31, 0, 0);
        cyc(1, 8'h32, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("boundary_r121", 128'(regs[121]), 128'h31);

        // Byte and stop together, then a fresh command.
        cyc(1, 8'h90, 0, 0);
        cyc(1, 8'h77, 1, 0);
        cyc(1, 8'h0C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("stop_r16", 128'(regs[16]), 128'h77);

        // Reset in the middle of a write burst.
        cyc(1, 8'h82, 0, 0);
        cyc(1, 8'h21, 0, 0);
        rx_valid = 1; rx_data = 8'h99;
        @(posedge clk);
        #1;
        rx_valid = 0;
        #2 rst = 0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst = 1;
        cyc(1, 8'h03, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[6:0] = 7'($urandom_range(116, 127));
            if (m_mode == M_IDLE) v = ($urandom_range(0, 2) == 0);
            else                  v = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 15) == 0);
            cyc(v, d, s, t);
        end

        nbad_regs = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (regs[i] !== mregs[i]) nbad_regs++;
        end
        chk("regfile", 128'(nbad_regs), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
